// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU operand/result
// bus and the tagged response channel. The arbiter sits on the slave
// side; requesters, ALU and response consumer sit on the master side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r0_ready;
  logic [2:0]       r0_ctrl;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;

  logic             r1_valid;
  logic             r1_ready;
  logic [2:0]       r1_ctrl;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;

  logic             busy;

  modport slave (
    input  r0_valid, r0_ctrl, r0_a, r0_b,
    output r0_ready,
    input  r1_valid, r1_ctrl, r1_a, r1_b,
    output r1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result,
    output resp_valid, resp_id, resp_data,
    input  resp_ready,
    output busy
  );

  modport master (
    output r0_valid, r0_ctrl, r0_a, r0_b,
    input  r0_ready,
    output r1_valid, r1_ctrl, r1_a, r1_b,
    input  r1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result,
    input  resp_valid, resp_id, resp_data,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Operands are registered toward the ALU; multiply is given MUL_LAT
// extra evaluation cycles so the ALU's multiplier path can be multicycled.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no op in flight, may accept
// EXEC  | ALU evaluating the latched op (cnt counts mul cycles)
// RESP  | result held on resp_* until consumed; may accept on retire
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL   = 3'b111;
  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT);

  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             id_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] data_q;
  logic             rvalid_q;
  logic             rid_q;

  logic             accept_ok;
  logic             win_id;
  logic             grant;
  logic             exec_last;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [2:0]       win_ctrl;

  // Arbitration: single valid requester wins, ties go to the prio pointer
  always_comb begin
    accept_ok = 1'b0;
    win_id    = 1'b0;
    grant     = 1'b0;
    accept_ok = !rst && ((state_q == IDLE) || ((state_q == RESP) && bus.resp_ready));
    if (bus.r0_valid && bus.r1_valid) begin
      win_id = prio_q;
    end else begin
      win_id = bus.r1_valid;
    end
    grant    = accept_ok && (bus.r0_valid || bus.r1_valid);
    win_a    = win_id ? bus.r1_a    : bus.r0_a;
    win_b    = win_id ? bus.r1_b    : bus.r0_b;
    win_ctrl = win_id ? bus.r1_ctrl : bus.r0_ctrl;
  end

  // Next-state logic; non-mul ops finish after one EXEC cycle
  always_comb begin
    state_d   = state_q;
    exec_last = (ctrl_q != OP_MUL) || (cnt_q == MUL_LAST);
    case (state_q)
      IDLE: if (grant) state_d = EXEC;
      EXEC: if (exec_last) state_d = RESP;
      RESP: if (bus.resp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch on grant, mul cycle count, response capture and retire
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      id_q     <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (grant) begin
        a_q    <= win_a;
        b_q    <= win_b;
        ctrl_q <= win_ctrl;
        id_q   <= win_id;
        prio_q <= ~win_id;
        cnt_q  <= '0;
      end else if ((state_q == EXEC) && !exec_last) begin
        cnt_q <= cnt_q + 4'd1;
      end

      if ((state_q == EXEC) && exec_last) begin
        data_q   <= bus.alu_result;
        rid_q    <= id_q;
        rvalid_q <= 1'b1;
      end else if ((state_q == RESP) && bus.resp_ready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.r0_ready   = grant && !win_id;
  assign bus.r1_ready   = grant && win_id;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_data  = data_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: provides the shared ALU, drives directed
// request sequences and checks every cycle against a transaction model
// that tracks the in-flight op by its due cycle.
module tb_alu_share_arbiter;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~(a & b);
      3'd5: return a ^ b;
      3'd6: return ~(a | b);
      default: return p[31:0];
    endcase
  endfunction

  // The shared combinational ALU
  always_comb bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction model: one op in flight, visible on resp_* from its due cycle
  int          cyc = 0;
  bit          model_on = 1'b0;
  bit          m_have;
  bit          m_id;
  logic [31:0] m_data;
  int          m_due;
  bit          m_prio;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  bit          resp_vis, acc, win, grant;

  always @(negedge clk) begin
    cyc++;
    resp_vis = m_have && (cyc >= m_due);
    acc      = !rst && (!m_have || (resp_vis && bus.resp_ready));
    win      = (bus.r0_valid && bus.r1_valid) ? m_prio : bus.r1_valid;
    grant    = acc && (bus.r0_valid || bus.r1_valid);
    if (model_on) begin
      check("r0_ready", 32'(bus.r0_ready), 32'(grant && !win));
      check("r1_ready", 32'(bus.r1_ready), 32'(grant && win));
      check("busy", 32'(bus.busy), 32'(m_have));
      check("resp_valid", 32'(bus.resp_valid), 32'(resp_vis));
      if (resp_vis) begin
        check("resp_id", 32'(bus.resp_id), 32'(m_id));
        check("resp_data", bus.resp_data, m_data);
      end
      check("alu_a", bus.alu_a, m_a);
      check("alu_b", bus.alu_b, m_b);
      check("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_ctrl));
    end
    if (rst) begin
      m_have   = 1'b0;
      m_prio   = 1'b0;
      m_a      = '0;
      m_b      = '0;
      m_ctrl   = '0;
      model_on = 1'b1;
    end else begin
      if (resp_vis && bus.resp_ready) m_have = 1'b0;
      if (grant) begin
        m_have = 1'b1;
        m_id   = win;
        m_a    = win ? bus.r1_a : bus.r0_a;
        m_b    = win ? bus.r1_b : bus.r0_b;
        m_ctrl = win ? bus.r1_ctrl : bus.r0_ctrl;
        m_data = alu_fn(m_ctrl, m_a, m_b);
        m_due  = cyc + 2 + ((m_ctrl == 3'b111) ? MUL_LAT : 0);
        m_prio = !win;
      end
    end
  end

  task automatic set_req(input bit who, input bit v, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      bus.r1_valid = v; bus.r1_ctrl = c; bus.r1_a = a; bus.r1_b = b;
    end else begin
      bus.r0_valid = v; bus.r0_ctrl = c; bus.r0_a = a; bus.r0_b = b;
    end
  endtask

  // Present one op, wait for its ready, then withdraw it after the accept edge
  task automatic issue(input bit who, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    int  n = 0;
    bit  rdy;
    @(posedge clk); #1;
    set_req(who, 1'b1, c, a, b);
    do begin
      @(negedge clk);
      n++;
      rdy = who ? bus.r1_ready : bus.r0_ready;
    end while (!rdy && n < 50);
    check("issue_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    set_req(who, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // Wait for the next resp_valid cycle and pin it against literal values
  task automatic wait_resp(input string name, input bit id, input logic [31:0] data,
                           input int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 60);
    check({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({name, "_id"}, 32'(bus.resp_id), 32'(id));
    check({name, "_data"}, bus.resp_data, data);
    if (lat >= 0) check({name, "_lat"}, n, lat);
  endtask

  task automatic retire();
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);

    // Single add
    issue(1'b0, 3'd0, 32'd5, 32'd7);
    wait_resp("add", 1'b0, 32'd12, 2);
    retire();

    // Multiply: low word of 2^32 is zero
    issue(1'b1, 3'd7, 32'h0001_0000, 32'h0001_0000);
    wait_resp("mul", 1'b1, 32'h0, 2 + MUL_LAT);
    retire();

    // Contention with both held valid and the consumer always ready
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 1'b1, 3'd1, 32'd10, 32'd3);
    set_req(1'b1, 1'b1, 3'd5, 32'hF0F0_0000, 32'hFFFF_0000);
    wait_resp("rr0", 1'b0, 32'd7, -1);
    wait_resp("rr1", 1'b1, 32'h0F0F_0000, 2);
    wait_resp("rr2", 1'b0, 32'd7, 2);
    wait_resp("rr3", 1'b1, 32'h0F0F_0000, 2);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    wait_resp("rr4", 1'b0, 32'd7, 2);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Backpressure: response holds, pending r1 waits for resp_ready
    issue(1'b0, 3'd6, 32'h0, 32'h0);
    set_req(1'b1, 1'b1, 3'd3, 32'd3, 32'd5);
    wait_resp("nor", 1'b0, 32'hFFFF_FFFF, 2);
    repeat (4) begin
      @(negedge clk);
      check("hold_data", bus.resp_data, 32'hFFFF_FFFF);
      check("hold_r1_ready", 32'(bus.r1_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_r1_ready", 32'(bus.r1_ready), 32'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    wait_resp("or", 1'b1, 32'd7, 2);
    retire();

    // Wrap-around
    issue(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1);
    wait_resp("wrap_add", 1'b0, 32'h0, 2);
    retire();
    issue(1'b1, 3'd1, 32'h0, 32'd1);
    wait_resp("wrap_sub", 1'b1, 32'hFFFF_FFFF, 2);
    retire();

    // Reset during a multiply's EXEC
    issue(1'b0, 3'd7, 32'd3, 32'd4);
    rst = 1'b1;
    set_req(1'b0, 1'b1, 3'd2, 32'hFF, 32'h0F);
    set_req(1'b1, 1'b1, 3'd3, 32'd1, 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_alu_a", bus.alu_a, 32'd0);
    check("mrst_alu_b", bus.alu_b, 32'd0);
    check("mrst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("mrst_r0_ready", 32'(bus.r0_ready), 32'd1);
    check("mrst_r1_ready", 32'(bus.r1_ready), 32'd0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    wait_resp("post_rst0", 1'b0, 32'h0F, 2);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    wait_resp("post_rst1", 1'b1, 32'd3, 2);
    retire();

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (r0: execute stage, r1: auxiliary/debug unit) under valid/ready handshakes.
- Arbitrates round-robin, latches the winner's operands, and drives the ALU's A/B/ALUControl inputs from registers.
- Holds multiply (ctrl 3'b111) for extra cycles to meet FPGA timing.
- Returns the result on a single response channel tagged with the requester id.

Parameters:
- WIDTH, 32: operand/result width.
- MUL_LAT, 2: extra EXEC cycles for multiply, 0..15; 0 means single-cycle multiply.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- r0_valid  input  1  requester 0 has an op.
- r0_ready  output  1  requester 0 op accepted this cycle.
- r0_ctrl  input  3  requester 0 ALU opcode.
- r0_a, r0_b  input  WIDTH  requester 0 operands.
- r1_valid, r1_ready, r1_ctrl, r1_a, r1_b: same as r0, for requester 1.
- alu_a, alu_b  output  WIDTH  registered operands to the shared ALU.
- alu_ctrl  output  3  registered opcode to the shared ALU.
- alu_result  input  WIDTH  combinational ALU result.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  requester that issued the op.
- resp_data  output  WIDTH  captured result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Opcodes are passed through unchanged: 000 add, 001 sub, 010 and, 011 or, 100 nand, 101 xor, 110 nor, 111 mul. No opcode is illegal.
- States:
  - IDLE: no op in flight.
  - EXEC: ALU is evaluating the latched op.
  - RESP: result held until consumed.
- accept_ok = (state==IDLE) or (state==RESP and resp_ready).
- Arbitration:
  - Only one valid requester: it wins.
  - Both valid: the winner is the one selected by priority pointer prio (0 favours r0).
  - Winner: prio <= ~winner_id.
  - Without a grant, prio holds.
- rN_ready = accept_ok and (requester N wins). Ready is combinational from valid; requesters must not derive valid from ready. At most one ready is high per cycle.
- On handshake at edge T:
  - alu_a, alu_b, alu_ctrl and the internal id register are loaded; cnt <= 0; state <= EXEC.
  - alu_* remain stable until the next accept; they are not cleared in IDLE.
- EXEC:
  - Non-mul: exactly 1 cycle.
  - Mul: 1+MUL_LAT cycles, cnt increments each cycle.
  - On the last EXEC cycle: resp_data <= alu_result, resp_id <= id, resp_valid <= 1, state <= RESP.
- Latency from accept edge T to resp_valid high:
  - Non-mul: 2 edges (T+2).
  - Mul: 2+MUL_LAT edges.
- RESP: resp_valid, resp_data and resp_id hold stable while resp_ready=0.
  - resp_ready=1 and a request is valid: response retires and the new op is accepted in the same cycle, state <= EXEC, resp_valid <= 0. This gives back-to-back throughput of one non-mul op per 2 cycles.
  - resp_ready=1 and no request: resp_valid <= 0, state <= IDLE.
- No requests are accepted in EXEC; both readys are 0.
- Requester payload may change freely while valid=0. Operands are sampled only at handshake.
- Reset, in any state including mid-EXEC or RESP:
  - In-flight op is dropped with no response.
  - state=IDLE, resp_valid=0, resp_data=0, resp_id=0, alu_a=0, alu_b=0, alu_ctrl=0, prio=0, cnt=0, busy=0.
  - With rst high, both readys are 0.
- Arithmetic: results wrap modulo 2^WIDTH. Multiply returns the low WIDTH bits. No flags are produced.

Test Plan:
- Single op: r0 add, a=5, b=7, at edge T -> r0_ready high at T. resp_valid at T+2 with resp_data=12, resp_id=0. busy high from T+1 until the handshake.
- Contention: r0 sub (10,3) and r1 xor (0xF0F0_0000,0xFFFF_0000) both held valid, resp_ready=1.
  - r0 is granted first (prio=0), result 7, id 0.
  - r1 is then granted in the same cycle r0's response retires, result 0x0F0F_0000, id 1.
  - Grants continue to alternate.
- Multiply with MUL_LAT=2: r1 mul a=0x0001_0000, b=0x0001_0000 -> resp_valid at T+4, resp_data=0 (low word), resp_id=1. No readys during EXEC.
- Backpressure: r0 nor (0,0) with resp_ready held low for 5 cycles -> resp_data=0xFFFF_FFFF stable for all 5 cycles. Pending r1 is not accepted until the cycle resp_ready rises.
- Reset mid-op: assert rst during EXEC of a mul -> next cycle resp_valid=0, busy=0, alu_*=0, and no response for that op. The first op after reset is granted to r0 even if r1 is also valid.
- Wrap: add 0xFFFF_FFFF+1 -> 0. sub 0-1 -> 0xFFFF_FFFF.
